// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: opcodes, flag bit positions, FSM encoding and opcode helpers
// shared by the ALU arbiter/controller and its ALU.
package alu_ctrl_pkg;

  // Opcode map. 0x08-0x0B are flag-only forms of AND/EOR/SUB/ADD,
  // 0x10-0x12 are address calculations that never touch the flags.
  localparam logic [4:0] OP_AND  = 5'h00;
  localparam logic [4:0] OP_EOR  = 5'h01;
  localparam logic [4:0] OP_SUB  = 5'h02;
  localparam logic [4:0] OP_RSB  = 5'h03;
  localparam logic [4:0] OP_ADD  = 5'h04;
  localparam logic [4:0] OP_ADC  = 5'h05;
  localparam logic [4:0] OP_SBC  = 5'h06;
  localparam logic [4:0] OP_RSC  = 5'h07;
  localparam logic [4:0] OP_TST  = 5'h08;
  localparam logic [4:0] OP_TEQ  = 5'h09;
  localparam logic [4:0] OP_CMP  = 5'h0A;
  localparam logic [4:0] OP_CMN  = 5'h0B;
  localparam logic [4:0] OP_ORR  = 5'h0C;
  localparam logic [4:0] OP_MOV  = 5'h0D;
  localparam logic [4:0] OP_BIC  = 5'h0E;
  localparam logic [4:0] OP_MVN  = 5'h0F;
  localparam logic [4:0] OP_AADD = 5'h10;
  localparam logic [4:0] OP_ASUB = 5'h11;
  localparam logic [4:0] OP_AIDX = 5'h12;

  localparam logic [4:0] OP_LAST_LEGAL = 5'h12;

  // Bit positions inside the {N,Z,C,V} flag register
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Control part of a latched request; operands are held separately
  typedef struct packed {
    logic [4:0] op;
    logic       s;
    logic       id;
  } req_t;

  // Test/compare forms execute as their plain ALU counterpart
  function automatic logic [4:0] remap_op(input logic [4:0] op);
    logic [4:0] r;
    r = op;
    case (op)
      OP_TST:  r = OP_AND;
      OP_TEQ:  r = OP_EOR;
      OP_CMP:  r = OP_SUB;
      OP_CMN:  r = OP_ADD;
      default: r = op;
    endcase
    return r;
  endfunction

  function automatic logic is_cmp_op(input logic [4:0] op);
    return (op >= OP_TST) && (op <= OP_CMN);
  endfunction

  // Applied to the remapped opcode, so CMP/CMN are covered as SUB/ADD
  function automatic logic is_arith_op(input logic [4:0] op);
    return (op >= OP_SUB) && (op <= OP_RSC);
  endfunction

endpackage

// File: rtl/arithmetic_logic_unit.sv
// arithmetic_logic_unit: combinational 5-bit-opcode ALU. One shared adder
// serves every arithmetic and address op; logic/move ops pass Cin to cout.
module arithmetic_logic_unit
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [4:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  output logic [DATA_W-1:0] result,
  output logic              cout,
  output logic              vout,
  output logic              zero
);

  logic [DATA_W-1:0] add_x, add_y, logic_res;
  logic              add_ci, use_sum;
  logic [DATA_W:0]   sum;

  // Operand selection for the adder and the logic-op result
  always_comb begin
    add_x     = a;
    add_y     = b;
    add_ci    = 1'b0;
    use_sum   = 1'b0;
    logic_res = '0;
    case (op)
      OP_AND:  logic_res = a & b;
      OP_EOR:  logic_res = a ^ b;
      OP_SUB:  begin add_y = ~b; add_ci = 1'b1; use_sum = 1'b1; end
      OP_RSB:  begin add_x = b; add_y = ~a; add_ci = 1'b1; use_sum = 1'b1; end
      OP_ADD:  use_sum = 1'b1;
      OP_ADC:  begin add_ci = cin; use_sum = 1'b1; end
      OP_SBC:  begin add_y = ~b; add_ci = cin; use_sum = 1'b1; end
      OP_RSC:  begin add_x = b; add_y = ~a; add_ci = cin; use_sum = 1'b1; end
      OP_ORR:  logic_res = a | b;
      OP_MOV:  logic_res = b;
      OP_BIC:  logic_res = a & ~b;
      OP_MVN:  logic_res = ~b;
      OP_AADD: use_sum = 1'b1;
      OP_ASUB: begin add_y = ~b; add_ci = 1'b1; use_sum = 1'b1; end
      OP_AIDX: begin add_y = b << 2; use_sum = 1'b1; end
      default: logic_res = '0;
    endcase
  end

  assign sum    = {1'b0, add_x} + {1'b0, add_y} + {{DATA_W{1'b0}}, add_ci};
  assign result = use_sum ? sum[DATA_W-1:0] : logic_res;
  assign cout   = use_sum ? sum[DATA_W] : cin;
  assign vout   = use_sum &&
                  (add_x[DATA_W-1] == add_y[DATA_W-1]) &&
                  (sum[DATA_W-1] != add_x[DATA_W-1]);
  assign zero   = (result == '0);

endmodule

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: 2-way round-robin grant. On a tie the requester not served
// last wins; the pointer only moves when a grant is actually taken.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       adv,
  output logic [1:0] gnt
);

  logic last;

  // One-hot grant; a single requester always wins outright
  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = last ? 2'b01 : 2'b10;
  end

  // Last-served pointer; starts at 1 so requester 0 wins the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   last <= 1'b1;
    else if (adv) last <= gnt[1];
  end

endmodule

// File: rtl/alu_arbiter_ctrl.sv
// alu_arbiter_ctrl: shares one ALU between two requesters. Each op runs
// IDLE -> EXEC -> RESP; the block owns the NZCV register and feeds C back
// as ALU carry-in. Define ALU_ARB_PERF_EN to add per-requester accept
// counters (perf_cnt0/perf_cnt1, saturating at 0xFFFF).
module alu_arbiter_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [4:0]        req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req0_s,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [4:0]        req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic              req1_s,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_wb,
  output logic              rsp_err,
  output logic [3:0]        flags
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [15:0]       perf_cnt0,
  output logic [15:0]       perf_cnt1
`endif
);

  state_t            state, state_nxt;
  logic [1:0]        req_vld, gnt;
  logic              idle_live, accept;
  req_t              cur;
  logic [DATA_W-1:0] cur_a, cur_b;

  logic [4:0]        exe_op;
  logic              exe_err, exe_wb, flag_upd;
  logic [DATA_W-1:0] alu_res, exe_data;
  logic              alu_cout, alu_v, alu_zero_unused;
  logic [3:0]        flags_nxt;

  assign req_vld = {req1_valid, req0_valid};

  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req_vld),
    .adv   (accept),
    .gnt   (gnt)
  );

  // Ready is held low while reset is asserted, even though state is IDLE
  assign idle_live  = (state == ST_IDLE) && rst_n;
  assign req0_ready = idle_live && gnt[0];
  assign req1_ready = idle_live && gnt[1];
  assign accept     = req0_ready || req1_ready;
  assign rsp_valid  = (state == ST_RESP);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // FSM next state: EXEC is always exactly one cycle
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_EXEC;
      ST_EXEC: state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Latch the granted request on the handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur   <= '0;
      cur_a <= '0;
      cur_b <= '0;
    end else if (accept) begin
      if (gnt[1]) begin
        cur   <= '{op: req1_op, s: req1_s, id: 1'b1};
        cur_a <= req1_a;
        cur_b <= req1_b;
      end else begin
        cur   <= '{op: req0_op, s: req0_s, id: 1'b0};
        cur_a <= req0_a;
        cur_b <= req0_b;
      end
    end
  end

  assign exe_op = remap_op(cur.op);

  arithmetic_logic_unit #(.DATA_W(DATA_W)) u_alu (
    .op     (exe_op),
    .a      (cur_a),
    .b      (cur_b),
    .cin    (flags[FLAG_C]),
    .result (alu_res),
    .cout   (alu_cout),
    .vout   (alu_v),
    .zero   (alu_zero_unused)
  );

  // Result/flag decode for the op in EXEC. Z is derived here rather than
  // taken from the ALU so it is always the same comparison as N's source.
  always_comb begin
    exe_err   = (cur.op > OP_LAST_LEGAL);
    exe_wb    = !exe_err && !is_cmp_op(cur.op);
    exe_data  = exe_err ? '0 : alu_res;
    flag_upd  = (state == ST_EXEC) && cur.s && !exe_err && (cur.op <= OP_MVN);
    flags_nxt = flags;
    if (flag_upd) begin
      flags_nxt[FLAG_N] = alu_res[DATA_W-1];
      flags_nxt[FLAG_Z] = (alu_res == '0);
      flags_nxt[FLAG_C] = alu_cout;
      if (is_arith_op(exe_op)) flags_nxt[FLAG_V] = alu_v;
    end
  end

  // Response and flag registers, loaded at the end of EXEC and then held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_id   <= 1'b0;
      rsp_data <= '0;
      rsp_wb   <= 1'b0;
      rsp_err  <= 1'b0;
      flags    <= 4'b0000;
    end else if (state == ST_EXEC) begin
      rsp_id   <= cur.id;
      rsp_data <= exe_data;
      rsp_wb   <= exe_wb;
      rsp_err  <= exe_err;
      flags    <= flags_nxt;
    end
  end

`ifdef ALU_ARB_PERF_EN
  // Saturating per-requester accept counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cnt0 <= '0;
      perf_cnt1 <= '0;
    end else begin
      if (req0_ready && perf_cnt0 != 16'hFFFF) perf_cnt0 <= perf_cnt0 + 16'd1;
      if (req1_ready && perf_cnt1 != 16'hFFFF) perf_cnt1 <= perf_cnt1 + 16'd1;
    end
  end
`endif

endmodule
